// File: rtl/input_debouncer_pkg.sv
// Shared types and defaults for the input debouncer.
package debounce_pkg;

  localparam int unsigned DEF_STABLE_CYCLES = 4;
  localparam int unsigned DEF_CNT_WIDTH     = 8;
  // Run counter width; covers STABLE_CYCLES up to 255.
  localparam int unsigned RUN_W             = 8;

  typedef enum logic [1:0] {
    LOW_STABLE  = 2'd0,
    CHECK_HIGH  = 2'd1,
    HIGH_STABLE = 2'd2,
    CHECK_LOW   = 2'd3
  } db_state_e;

endpackage

// File: rtl/input_debouncer_flex_counter.sv
// Up-counter with synchronous clear that wraps to zero after reaching
// rollover_val; rollover_flag is high while the count equals rollover_val.
module flex_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             count_enable,
  input  logic [WIDTH-1:0] rollover_val,
  output logic             rollover_flag
);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_next;

  // Next count: clear wins, otherwise increment and wrap at rollover_val.
  always_comb begin
    count_next = count;
    if (clear) begin
      count_next = '0;
    end else if (count_enable) begin
      if (count == rollover_val) begin
        count_next = '0;
      end else begin
        count_next = count + WIDTH'(1);
      end
    end
  end

  // Count register and registered terminal-count flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      count         <= '0;
      rollover_flag <= 1'b0;
    end else begin
      count         <= count_next;
      rollover_flag <= (count_next == rollover_val);
    end
  end

endmodule

// File: rtl/input_debouncer.sv
// Debounces an already-synchronized level: a change is accepted only after
// STABLE_CYCLES consecutive identical samples; emits edge strobes and counts
// accepted rising changes.
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned CNT_WIDTH     = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sync_in,
  input  logic                 clear,
  output logic                 db_out,
  output logic                 rise_pulse,
  output logic                 fall_pulse,
  output logic [CNT_WIDTH-1:0] event_count
);

  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(STABLE_CYCLES - 1);

  db_state_e state;
  db_state_e next_state;
  logic      run_clear;
  logic      run_enable;
  logic      run_done;
  logic      rise_next;
  logic      fall_next;
  logic      db_next;

  // Run counter: number of consecutive samples opposing the accepted level.
  flex_counter #(
    .WIDTH (RUN_W)
  ) u_run_counter (
    .clk           (clk),
    .rst           (rst),
    .clear         (run_clear),
    .count_enable  (run_enable),
    .rollover_val  (RUN_LAST),
    .rollover_flag (run_done)
  );

  // State register and registered outputs; reset aborts silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LOW_STABLE;
      db_out      <= 1'b0;
      rise_pulse  <= 1'b0;
      fall_pulse  <= 1'b0;
      event_count <= '0;
    end else begin
      state      <= next_state;
      db_out     <= db_next;
      rise_pulse <= rise_next;
      fall_pulse <= fall_next;
      if (clear) begin
        event_count <= '0;
      end else if (rise_next) begin
        event_count <= event_count + CNT_WIDTH'(1);
      end
    end
  end

  // Next-state, run-counter control and strobe decode.
  always_comb begin
    next_state = state;
    run_clear  = 1'b0;
    run_enable = 1'b0;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    case (state)
      LOW_STABLE: begin
        if (sync_in) begin
          next_state = CHECK_HIGH;
          run_enable = 1'b1;
        end else begin
          run_clear = 1'b1;
        end
      end
      CHECK_HIGH: begin
        if (!sync_in) begin
          next_state = LOW_STABLE;
          run_clear  = 1'b1;
        end else begin
          // Counter wraps to zero on the accepting sample.
          run_enable = 1'b1;
          if (run_done) begin
            next_state = HIGH_STABLE;
            rise_next  = 1'b1;
          end
        end
      end
      HIGH_STABLE: begin
        if (!sync_in) begin
          next_state = CHECK_LOW;
          run_enable = 1'b1;
        end else begin
          run_clear = 1'b1;
        end
      end
      CHECK_LOW: begin
        if (sync_in) begin
          next_state = HIGH_STABLE;
          run_clear  = 1'b1;
        end else begin
          run_enable = 1'b1;
          if (run_done) begin
            next_state = LOW_STABLE;
            fall_next  = 1'b1;
          end
        end
      end
      default: begin
        next_state = LOW_STABLE;
        run_clear  = 1'b1;
      end
    endcase
    db_next = (next_state == HIGH_STABLE) || (next_state == CHECK_LOW);
  end

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench: three debouncer configurations share one randomized
// stimulus stream and are compared each cycle against a run-length model.
module tb_input_debouncer;

  logic clk = 1'b0;
  logic rst;
  logic sync_in;
  logic clear;

  logic       db_a, rise_a, fall_a;
  logic [7:0] cnt_a;
  logic       db_b, rise_b, fall_b;
  logic [1:0] cnt_b;
  logic       db_c, rise_c, fall_c;
  logic [7:0] cnt_c;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Model parameters per instance: stable samples needed and counter width.
  int ns [3] = '{4, 4, 2};
  int cw [3] = '{8, 2, 8};

  // Model state: accepted level, length of opposing run, pulses, count.
  bit db_m   [3];
  int run_m  [3];
  bit rise_m [3];
  bit fall_m [3];
  int cnt_m  [3];

  always #5 clk = ~clk;

  input_debouncer #(.STABLE_CYCLES(4), .CNT_WIDTH(8)) dut_a (
    .clk(clk), .rst(rst), .sync_in(sync_in), .clear(clear),
    .db_out(db_a), .rise_pulse(rise_a), .fall_pulse(fall_a), .event_count(cnt_a)
  );

  input_debouncer #(.STABLE_CYCLES(4), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .rst(rst), .sync_in(sync_in), .clear(clear),
    .db_out(db_b), .rise_pulse(rise_b), .fall_pulse(fall_b), .event_count(cnt_b)
  );

  input_debouncer #(.STABLE_CYCLES(2), .CNT_WIDTH(8)) dut_c (
    .clk(clk), .rst(rst), .sync_in(sync_in), .clear(clear),
    .db_out(db_c), .rise_pulse(rise_c), .fall_pulse(fall_c), .event_count(cnt_c)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one sampling edge.
  task automatic model_step(input bit r, input bit s, input bit c);
    for (int i = 0; i < 3; i++) begin
      rise_m[i] = 1'b0;
      fall_m[i] = 1'b0;
      if (r) begin
        db_m[i]  = 1'b0;
        run_m[i] = 0;
        cnt_m[i] = 0;
      end else begin
        if (s != db_m[i]) begin
          run_m[i]++;
          if (run_m[i] == ns[i]) begin
            db_m[i]  = s;
            run_m[i] = 0;
            if (s) rise_m[i] = 1'b1;
            else   fall_m[i] = 1'b1;
          end
        end else begin
          run_m[i] = 0;
        end
        if (c)              cnt_m[i] = 0;
        else if (rise_m[i]) cnt_m[i] = (cnt_m[i] + 1) % (1 << cw[i]);
      end
    end
  endtask

  task automatic compare_all();
    check_val("a_db",   int'(db_a),   int'(db_m[0]));
    check_val("a_rise", int'(rise_a), int'(rise_m[0]));
    check_val("a_fall", int'(fall_a), int'(fall_m[0]));
    check_val("a_cnt",  int'(cnt_a),  cnt_m[0]);
    check_val("b_db",   int'(db_b),   int'(db_m[1]));
    check_val("b_rise", int'(rise_b), int'(rise_m[1]));
    check_val("b_fall", int'(fall_b), int'(fall_m[1]));
    check_val("b_cnt",  int'(cnt_b),  cnt_m[1]);
    check_val("c_db",   int'(db_c),   int'(db_m[2]));
    check_val("c_rise", int'(rise_c), int'(rise_m[2]));
    check_val("c_fall", int'(fall_c), int'(fall_m[2]));
    check_val("c_cnt",  int'(cnt_c),  cnt_m[2]);
  endtask

  // Drive one cycle of inputs, clock it, then compare just after the edge.
  task automatic drive(input bit r, input bit s, input bit c);
    rst     = r;
    sync_in = s;
    clear   = c;
    @(posedge clk);
    #1;
    model_step(r, s, c);
    compare_all();
  endtask

  task automatic hold(input bit s, input int n);
    for (int k = 0; k < n; k++) drive(1'b0, s, 1'b0);
  endtask

  initial begin
    int seq_b [5] = '{1, 2, 3, 0, 1};
    rst     = 1'b1;
    sync_in = 1'b1;
    clear   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      db_m[i] = 0; run_m[i] = 0; cnt_m[i] = 0; rise_m[i] = 0; fall_m[i] = 0;
    end

    // Reset held with sync_in high, then a clean rise.
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    hold(1'b1, 3);
    check_val("pre_accept_db", int'(db_a), 0);
    drive(1'b0, 1'b1, 1'b0);
    check_val("accept_db",   int'(db_a),   1);
    check_val("accept_rise", int'(rise_a), 1);
    check_val("accept_cnt",  int'(cnt_a),  1);
    hold(1'b1, 2);

    // Short low glitch, then a clean fall.
    hold(1'b0, 3);
    hold(1'b1, 2);
    hold(1'b0, 4);
    check_val("fall_pulse", int'(fall_a), 1);
    check_val("fall_cnt",   int'(cnt_a),  1);
    hold(1'b0, 2);

    // Short high glitch.
    hold(1'b1, 3);
    hold(1'b0, 3);
    check_val("glitch_cnt", int'(cnt_a), 1);

    // Clean rise/fall pairs; two-bit counter wraps.
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    for (int p = 0; p < 5; p++) begin
      hold(1'b1, 5);
      check_val("wrap_seq", int'(cnt_b), seq_b[p]);
      hold(1'b0, 5);
    end

    // Clear coincident with the accepting edge, then clear on the pulse cycle.
    hold(1'b1, 3);
    drive(1'b0, 1'b1, 1'b1);
    check_val("clr_coinc_cnt", int'(cnt_a), 0);
    check_val("clr_coinc_db",  int'(db_a),  1);
    hold(1'b0, 5);
    hold(1'b1, 4);
    drive(1'b0, 1'b1, 1'b1);
    check_val("clr_next_cnt", int'(cnt_a), 0);
    check_val("clr_next_db",  int'(db_a),  1);

    // Reset while high and mid-check: no strobes produced.
    drive(1'b1, 1'b1, 1'b0);
    check_val("rst_high_fall", int'(fall_a), 0);
    check_val("rst_high_db",   int'(db_a),   0);
    hold(1'b1, 2);
    drive(1'b1, 1'b1, 1'b0);
    hold(1'b1, 3);
    check_val("rst_mid_db", int'(db_a), 0);
    hold(1'b1, 3);

    // Randomized runs with occasional clear and reset.
    for (int r = 0; r < 600; r++) begin
      bit lvl = 1'($urandom_range(0, 1));
      int len = int'($urandom_range(1, 7));
      for (int k = 0; k < len; k++) begin
        drive(($urandom_range(0, 99) == 0), lvl, ($urandom_range(0, 15) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 SHALL provide parameter STABLE_CYCLES, default 4, number of consecutive identical samples needed to accept a level change; legal range 2..255.
REQ-002 SHALL provide parameter CNT_WIDTH, default 8, width of event_count.
REQ-003 SHALL provide port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL provide port sync_in, input, 1, level from the upstream two-flop synchronizer, already in the clk domain.
REQ-006 SHALL provide port clear, input, 1, synchronous clear of event_count.
REQ-007 SHALL provide port db_out, output, 1, debounced level, registered.
REQ-008 SHALL provide port rise_pulse, output, 1, one-cycle strobe on accepted 0->1 change, registered.
REQ-009 SHALL provide port fall_pulse, output, 1, one-cycle strobe on accepted 1->0 change, registered.
REQ-010 SHALL provide port event_count, output, CNT_WIDTH, count of accepted rising changes, registered.

Function
REQ-011 SHALL implement four states: LOW_STABLE, CHECK_HIGH, HIGH_STABLE, CHECK_LOW.
REQ-012 LOW_STABLE: sample sync_in=1 -> CHECK_HIGH with run counter=1; else remain, counter=0.
REQ-013 CHECK_HIGH: sample 0 -> LOW_STABLE, counter=0; sample 1 with counter==STABLE_CYCLES-1 -> HIGH_STABLE, counter=0; otherwise counter+1.
REQ-014 HIGH_STABLE and CHECK_LOW SHALL mirror REQ-012/013 with polarities inverted, returning to LOW_STABLE on acceptance.
REQ-015 db_out SHALL be 1 exactly while state is HIGH_STABLE or CHECK_LOW.
REQ-016 Latency: first 1 sampled at edge k, held through edge k+STABLE_CYCLES-1 -> db_out=1 after edge k+STABLE_CYCLES-1; symmetric for falls.
REQ-017 A glitch shorter than STABLE_CYCLES samples SHALL produce no change on any output.
REQ-018 rise_pulse SHALL be 1 for exactly the first cycle db_out=1; fall_pulse for exactly the first cycle db_out=0 after a high period; never both in one cycle.
REQ-019 event_count SHALL increment by 1 in the same cycle rise_pulse asserts; wraps from 2^CNT_WIDTH-1 to 0 with no flag.
REQ-020 clear SHALL set event_count to 0 at the next edge; clear coincident with an increment SHALL yield 0 (clear wins); clear SHALL not affect state, db_out or pulses.
REQ-021 sync_in of X SHALL not be required to resolve; bench drives only 0/1.

Reset
REQ-022 rst=1 at an edge SHALL force state LOW_STABLE, run counter 0, db_out 0, rise_pulse 0, fall_pulse 0, event_count 0.
REQ-023 rst asserted mid-check or while HIGH_STABLE SHALL abort silently: no fall_pulse generated by reset.
REQ-024 rst SHALL take priority over clear and sync_in.
REQ-025 After rst deasserts, sampling SHALL resume at the first edge with rst=0.

Structure
REQ-026 Package debounce_pkg SHALL hold the state enum typedef and default STABLE_CYCLES/CNT_WIDTH constants.
REQ-027 The run counter SHALL be a sub-module flex_counter (clear, count_enable, rollover_val, rollover_flag), instantiated once.
REQ-028 Expected implementation size 120-400 lines RTL including sub-module.

Verification
REQ-029 rst high 2 cycles with sync_in=1 -> all outputs 0; after release, sync_in held 1 -> db_out=1 and rise_pulse=1 after 4th sampling edge, event_count=1.
REQ-030 sync_in 1 for 3 cycles then 0 -> db_out stays 0, no pulses, event_count unchanged.
REQ-031 From high, sync_in 0 for 4 cycles -> db_out=0, fall_pulse one cycle, event_count unchanged.
REQ-032 CNT_WIDTH=2, 5 clean rise/fall pairs -> event_count sequence 1,2,3,0,1.
REQ-033 clear asserted on rise_pulse cycle -> event_count=0 next cycle, db_out=1 unaffected.
REQ-034 rst asserted 2 cycles into CHECK_HIGH and in HIGH_STABLE -> state LOW_STABLE, no pulses emitted.
